btn_digit_counter: RTL and testbench

- Input-side counterpart to the free-running digit display counter.
- Takes the raw, bouncy, asynchronous board push-button, synchronises and debounces it, and advances a decimal digit (0-9, wrapping) once per validated press.
- Drives one active-high seven-segment digit plus status pulses.
- Sits between the board button pin and the display.

---
 rtl/btn_digit_counter.sv | 109 ++++++++++
 tb/tb_btn_digit_counter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/btn_digit_counter.sv
// btn_digit_counter: debounced push-button driving a 0-9 seven-segment digit counter.
// Define BTN_AUTOREPEAT_EN to add hold-to-repeat increments.
module btn_digit_counter #(
  parameter int DEBOUNCE_CYCLES = 120000
`ifdef BTN_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY_CYCLES = 6000000,
  parameter int REPEAT_RATE_CYCLES = 2400000
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  output logic [3:0] digit,
  output logic [6:0] dig0,
  output logic       press,
  output logic       wrap
);
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;
  localparam logic [23:0] DC_LAST = 24'(DEBOUNCE_CYCLES - 1);
  state_t state, state_nxt;
  logic s1, s2, dc_done, inc, rep_fire;
  logic [23:0] dcnt;
  logic [3:0] digit_nxt;

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0: seg = 7'h3F;
      4'd1: seg = 7'h06;
      4'd2: seg = 7'h5B;
      4'd3: seg = 7'h4F;
      4'd4: seg = 7'h66;
      4'd5: seg = 7'h6D;
      4'd6: seg = 7'h7D;
      4'd7: seg = 7'h07;
      4'd8: seg = 7'h7F;
      4'd9: seg = 7'h6F;
      default: seg = 7'h00;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {s1, s2} <= 2'b00;
    else {s1, s2} <= {btn, s1};

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;

  assign dc_done = dcnt == DC_LAST;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:         state_nxt = s2 ? PRESS_WAIT : IDLE;
      PRESS_WAIT:   state_nxt = !s2 ? IDLE : dc_done ? HELD : PRESS_WAIT;
      HELD:         state_nxt = s2 ? HELD : RELEASE_WAIT;
      RELEASE_WAIT: state_nxt = s2 ? HELD : dc_done ? IDLE : RELEASE_WAIT;
      default:      state_nxt = IDLE;
    endcase
  end

  // Counter rests at zero outside the wait states, so every wait starts fresh.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) dcnt <= '0;
    else dcnt <= (state == PRESS_WAIT || state == RELEASE_WAIT) ? dcnt + 24'd1 : '0;

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [23:0] RD_LAST = 24'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [23:0] RR_LAST = 24'(REPEAT_RATE_CYCLES - 1);
  logic [23:0] rcnt;
  logic rep;
  assign rep_fire = state == HELD && s2 && rcnt == (rep ? RR_LAST : RD_LAST);
  // rep marks that the initial delay has elapsed and the faster rate applies.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rcnt <= '0;
      rep <= 1'b0;
    end else if (state != HELD) begin
      rcnt <= '0;
      rep <= 1'b0;
    end else if (rep_fire) begin
      rcnt <= '0;
      rep <= 1'b1;
    end else rcnt <= rcnt + 24'd1;
`else
  assign rep_fire = 1'b0;
`endif

  always_comb begin
    inc = (state == PRESS_WAIT && s2 && dc_done) || rep_fire;
    digit_nxt = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      digit <= 4'd0;
      dig0 <= 7'h3F;
      press <= 1'b0;
      wrap <= 1'b0;
    end else begin
      press <= inc;
      wrap <= inc && digit == 4'd9;
      if (inc) begin
        digit <= digit_nxt;
        dig0 <= seg(digit_nxt);
      end
    end
endmodule

// File: tb/tb_btn_digit_counter.sv
// tb_btn_digit_counter: directed stimulus with a scoreboard of expected increments.
module tb_btn_digit_counter;
  logic clk = 1'b0, rst_n = 1'b0, btn = 1'b0;
  logic [3:0] digit;
  logic [6:0] dig0;
  logic press, wrap;
  int total = 0, bad = 0;
  logic [11:0] q[$];
  logic [3:0] cnt = 4'd0;
  logic [6:0] segs [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  btn_digit_counter #(
    .DEBOUNCE_CYCLES(4)
`ifdef BTN_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY_CYCLES(20),
    .REPEAT_RATE_CYCLES(8)
`endif
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn(btn),
    .digit(digit),
    .dig0(dig0),
    .press(press),
    .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic push();
    logic w;
    w = cnt == 4'd9;
    cnt = w ? 4'd0 : cnt + 4'd1;
    q.push_back({cnt, segs[cnt], w});
  endtask

  task automatic do_press(input int hold);
    btn = 1'b1;
    push();
    repeat (hold) tick();
    btn = 1'b0;
    repeat (8) tick();
  endtask

  // Every press pulse must match the oldest outstanding expected increment.
  always @(negedge clk)
    if (press) begin
      total++;
      assert (q.size() != 0) else begin
        bad++;
        $error("FAIL stray_press got=digit %0d expected=no press", digit);
      end
      if (q.size() != 0) begin
        logic [11:0] e;
        e = q.pop_front();
        total++;
        assert ({digit, dig0, wrap} === e) else begin
          bad++;
          $error("FAIL press_value got=%h expected=%h", {digit, dig0, wrap}, e);
        end
      end
    end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_state", {press, wrap, digit, dig0}, {1'b0, 1'b0, 4'd0, 7'h3F});
    btn = 1'b1;
    push();
    repeat (6) tick();
    chk("clean_early", 16'(press), 16'd0);
    tick();
    chk("clean_press", {press, digit, dig0}, {1'b1, 4'd1, 7'h06});
    tick();
    chk("clean_pulse_end", 16'(press), 16'd0);
    repeat (12) tick();
    btn = 1'b0;
    repeat (8) tick();
    btn = 1'b1;
    repeat (3) tick();
    btn = 1'b0;
    tick();
    btn = 1'b1;
    repeat (2) tick();
    btn = 1'b0;
    repeat (8) tick();
    chk("bounce_digit", 16'(digit), 16'd1);
    do_press(10);
    chk("after_bounce_press", {digit, dig0}, {4'd2, 7'h5B});
    repeat (7) do_press(10);
    chk("pre_wrap", {digit, dig0}, {4'd9, 7'h6F});
    btn = 1'b1;
    push();
    repeat (6) tick();
    chk("wrap_early", {press, wrap}, 16'd0);
    tick();
    chk("wrap_edge", {press, wrap, digit, dig0}, {1'b1, 1'b1, 4'd0, 7'h3F});
    tick();
    chk("wrap_end", {press, wrap}, 16'd0);
    repeat (6) tick();
    btn = 1'b0;
    repeat (8) tick();
    btn = 1'b1;
    push();
    repeat (10) tick();
    btn = 1'b0;
    repeat (2) tick();
    btn = 1'b1;
    repeat (8) tick();
    btn = 1'b0;
    repeat (10) tick();
    chk("release_bounce", 16'(digit), 16'd1);
    repeat (4) do_press(10);
    chk("pre_reset", 16'(digit), 16'd5);
    btn = 1'b1;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("async_reset", {press, wrap, digit, dig0}, {1'b0, 1'b0, 4'd0, 7'h3F});
    cnt = 4'd0;
    tick();
    tick();
    rst_n = 1'b1;
    push();
    repeat (6) tick();
    chk("post_reset_early", 16'(press), 16'd0);
    tick();
    chk("post_reset_press", {press, digit}, {1'b1, 4'd1});
    repeat (4) tick();
    btn = 1'b0;
    repeat (8) tick();
    btn = 1'b1;
    push();
    if (AR) repeat (4) push();
    repeat (7) tick();
    for (int i = 0; i < 56; i++) begin
      chk($sformatf("hold_cycle_%0d", i), 16'(press),
          16'(i == 0 || (AR && i >= 20 && i <= 44 && (i - 20) % 8 == 0)));
      if (i == 49) btn = 1'b0;
      tick();
    end
    repeat (8) tick();
    chk("queue_empty", 16'(q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
